// File: rtl/cmp_word_seq.sv
// Sequential magnitude comparator: walks a WIDTH-bit operand pair MSB byte first
// through one shared 8-bit comparator. Optional macro CMP_SIGNED_EN selects two's complement.

module comparator_8bit (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic       gt_o,
  output logic       eq_o,
  output logic       lt_o
);

  assign gt_o = (a_i > b_i);
  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule

module cmp_word_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_greater,
  output logic             o_equal,
  output logic             o_less
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NBYTES - 1);

  typedef enum logic {IDLE, CMP} state_t;

  state_t           state_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic             greater_q;
  logic             equal_q;
  logic             less_q;

  logic [7:0] byteA;
  logic [7:0] byteB;
  logic [7:0] cmpA;
  logic [7:0] cmpB;
  logic       cmpGt;
  logic       cmpEq;
  logic       cmpLt;

  assign byteA = a_q[{idx_q, 3'b000} +: 8];
  assign byteB = b_q[{idx_q, 3'b000} +: 8];

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit of the top slice maps two's complement order onto unsigned order.
  logic flipSign;
  assign flipSign = (idx_q == TOP_IDX);
  assign cmpA = {byteA[7] ^ flipSign, byteA[6:0]};
  assign cmpB = {byteB[7] ^ flipSign, byteB[6:0]};
`else
  assign cmpA = byteA;
  assign cmpB = byteB;
`endif

  comparator_8bit uCmp (
    .a_i  (cmpA),
    .b_i  (cmpB),
    .gt_o (cmpGt),
    .eq_o (cmpEq),
    .lt_o (cmpLt)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      idx_q     <= TOP_IDX;
      a_q       <= '0;
      b_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            a_q     <= i_a;
            b_q     <= i_b;
            idx_q   <= TOP_IDX;
            busy_q  <= 1'b1;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!cmpEq) begin
            greater_q <= cmpGt;
            less_q    <= cmpLt;
            equal_q   <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (idx_q == '0) begin
            greater_q <= 1'b0;
            less_q    <= 1'b0;
            equal_q   <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_greater = greater_q;
  assign o_equal   = equal_q;
  assign o_less    = less_q;

endmodule

// File: tb/tb_cmp_word_seq.sv
// Scoreboard bench for cmp_word_seq: a driver pushes expected results from a
// plain-arithmetic model, a negedge monitor pops and compares on every o_done.

module tb_cmp_word_seq;

  localparam int WIDTH  = 32;
  localparam int NBYTES = WIDTH / 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] opA = '0;
  logic [WIDTH-1:0] opB = '0;
  logic             busy, done, greater, equal, less;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [2:0] lastFlags = 3'b000;

  typedef struct {
    logic [2:0] flags;
    int         doneCyc;
  } exp_t;

  exp_t expQ[$];

  cmp_word_seq #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_start   (start),
    .i_a       (opA),
    .i_b       (opB),
    .o_busy    (busy),
    .o_done    (done),
    .o_greater (greater),
    .o_equal   (equal),
    .o_less    (less)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: ordering from whole-word arithmetic, latency from the first differing byte.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                output logic [2:0] flags, output int k);
    logic gt, lt;
`ifdef CMP_SIGNED_EN
    gt = ($signed(a) > $signed(b));
    lt = ($signed(a) < $signed(b));
`else
    gt = (a > b);
    lt = (a < b);
`endif
    flags = {gt, (a == b), lt};
    k = NBYTES;
    for (int i = NBYTES - 1; i >= 0; i--) begin
      if (a[8*i +: 8] != b[8*i +: 8]) begin
        k = NBYTES - i;
        break;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, required, cyc);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the o_done edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit spurious, input bit holdStart);
    logic [2:0] flags;
    int         k;
    exp_t       e;
    model(a, b, flags, k);
    opA = a;
    opB = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.flags = flags;
    e.doneCyc = cyc + k;
    expQ.push_back(e);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    for (int j = 0; j < k; j++) begin
      start = holdStart | (spurious & ($urandom_range(0, 1) == 1));
      opA = $urandom();
      opB = $urandom();
      @(posedge clk);
      #1;
    end
    checkOutput("busy_in_done_cycle", 32'(busy), 32'd0);
    if (!holdStart) start = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] randB(input logic [WIDTH-1:0] a);
    logic [WIDTH-1:0] b;
    int pos;
    b = a;
    pos = $urandom_range(0, NBYTES);
    if (pos < NBYTES) b[8*pos +: 8] = 8'($urandom());
    for (int i = 0; i < pos; i++) b[8*i +: 8] = 8'($urandom());
    return b;
  endfunction

  // Monitor: every o_done must match the oldest expectation, on its exact cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (expQ.size() > 0 && cyc > expQ[0].doneCyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL done_timeout: no o_done by cycle %0d, expected at %0d", cyc, expQ[0].doneCyc);
        void'(expQ.pop_front());
      end
      if (done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: o_done=1 at cycle %0d, expected 0", cyc);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("done_cycle", 32'(cyc), 32'(e.doneCyc));
          checkOutput("result_flags", 32'({greater, equal, less}), 32'(e.flags));
          lastFlags = e.flags;
        end
      end else begin
        checkOutput("flags_stable", 32'({greater, equal, less}), 32'(lastFlags));
      end
    end
  end

  initial begin
    // Reset with random inputs and a start request that must not be taken.
    reset = 1'b1;
    start = 1'b1;
    opA = $urandom();
    opB = $urandom();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_flags", 32'({greater, equal, less}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("no_accept_during_reset", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(32'h12345678, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
    applyStimulus(32'h12345600, 32'h12345601, 1'b0, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Abort: spurious start at cycle 1, reset at cycle 2, no o_done may follow.
    opA = 32'h00000001;
    opB = 32'h00000002;
    start = 1'b1;
    @(posedge clk);
    #1;
    opA = 32'hDEADBEEF;
    opB = 32'h00000000;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b1;
    lastFlags = 3'b000;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_flags", 32'({done, greater, equal, less}), 32'd0);
    repeat (6) @(posedge clk);
    #1;

    for (int t = 0; t < 4; t++) applyStimulus(32'hFF000000, 32'h01000000, 1'b0, 1'b1);
    start = 1'b0;

    for (int t = 0; t < 80; t++) begin
      logic [WIDTH-1:0] a;
      a = $urandom();
      applyStimulus(a, randB(a), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (NBYTES + 3) @(posedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
